// File: rtl/params.sv
// Shared pipeline types.
//   word            - 32-bit datapath word
//   write_back_op_t - write-back source selection carried through MEM/WB
package params;

  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    NO_WRITE_BACK  = 2'd0,
    WRITE_BACK_OUT = 2'd1,
    WRITE_BACK_PC4 = 2'd2,
    WRITE_BACK_MEM = 2'd3
  } write_back_op_t;

endpackage

// File: rtl/memory_access_stage.sv
// memory_access_stage
// Pipeline stage between execute and write-back. Accepts one instruction per
// in_valid/in_ready handshake, runs any load/store on the data-memory bus and
// registers the MEM/WB values (pc_4, memory_out, write_back_ctrl).
//
// Ports:
//   clk, rst                 - clock (rising edge), async active-high reset
//   in_valid / in_ready      - instruction handshake from execute
//   alu_result, store_data   - effective address / result, and store value
//   pc_4_in                  - PC+4 of the offered instruction
//   mem_read, mem_write      - load / store request (never both)
//   mem_size, mem_unsigned   - access size (00 B, 01 H, 1x W) and zero-extend
//   write_back_ctrl_in       - write-back selection for the instruction
//   dmem_*                   - data-memory bus (req held until ack)
//   out_valid                - one-cycle completion pulse
//   pc_4, memory_out,
//   write_back_ctrl          - registered MEM/WB values
//   misalign_err             - completion pulse flag for a trapped misaligned access
//
// Optional feature macro: MEM_MISALIGN_TRAP_EN
//   defined   - misaligned accesses complete in one cycle with misalign_err=1
//               and never reach the bus
//   undefined - misaligned addresses are forced to natural alignment and the
//               access proceeds; misalign_err is always 0
module memory_access_stage
  import params::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  word            alu_result,
  input  word            store_data,
  input  word            pc_4_in,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [1:0]     mem_size,
  input  logic           mem_unsigned,
  input  write_back_op_t write_back_ctrl_in,
  output logic           dmem_req,
  output logic           dmem_we,
  output word            dmem_addr,
  output word            dmem_wdata,
  output logic [3:0]     dmem_be,
  input  logic           dmem_ack,
  input  word            dmem_rdata,
  output logic           out_valid,
  output word            pc_4,
  output word            memory_out,
  output write_back_op_t write_back_ctrl,
  output logic           misalign_err
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t         state;
  state_t         next_state;

  word            addr_q;
  word            store_data_q;
  word            pc_4_q;
  logic [1:0]     size_q;
  logic           unsigned_q;
  logic           we_q;
  write_back_op_t write_back_ctrl_q;

  logic           accept;
  logic           is_mem;
  logic           trap;
  logic [1:0]     lane;
  logic [7:0]     load_byte;
  logic [15:0]    load_half;
  word            load_value;

  // Handshake decode. A trapped misaligned access completes straight from
  // IDLE like a non-memory op, so it must never move the FSM to BUSY.
  always_comb begin
    in_ready = (state == IDLE);
    accept   = in_valid & in_ready;
    is_mem   = mem_read | mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
    trap     = is_mem & (((mem_size == 2'b01) & alu_result[0]) |
                         (mem_size[1] & (alu_result[1:0] != 2'b00)));
`else
    trap     = 1'b0;
`endif
  end

  // State register; reset abandons any access in flight, which drops
  // dmem_req immediately because the request is decoded from the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: only aligned (or alignment-forced) memory ops go to
  // the bus; the bus ack is the only way back out of BUSY.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept && is_mem && !trap) begin
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (dmem_ack) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Capture the instruction at accept so the bus signals stay stable for
  // the whole access regardless of what execute presents meanwhile.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q            <= '0;
      store_data_q      <= '0;
      pc_4_q            <= '0;
      size_q            <= '0;
      unsigned_q        <= 1'b0;
      we_q              <= 1'b0;
      write_back_ctrl_q <= NO_WRITE_BACK;
    end else if (accept) begin
      addr_q            <= alu_result;
      store_data_q      <= store_data;
      pc_4_q            <= pc_4_in;
      size_q            <= mem_size;
      unsigned_q        <= mem_unsigned;
      we_q              <= mem_write;
      write_back_ctrl_q <= write_back_ctrl_in;
    end
  end

  // Effective byte lane within the word. Without the trap the low address
  // bits are forced to natural alignment here rather than at capture, so a
  // store still reports its original alu_result on memory_out.
  always_comb begin
`ifdef MEM_MISALIGN_TRAP_EN
    lane = addr_q[1:0];
`else
    case (size_q)
      2'b00:   lane = addr_q[1:0];
      2'b01:   lane = {addr_q[1], 1'b0};
      default: lane = 2'b00;
    endcase
`endif
  end

  // Bus drive: byte enables select the addressed lanes and the store data
  // is replicated across lanes so memory can pick whichever lane is enabled.
  always_comb begin
    dmem_req  = (state == BUSY);
    dmem_we   = we_q;
    dmem_addr = {addr_q[31:2], 2'b00};
    case (size_q)
      2'b00: begin
        dmem_be    = 4'b0001 << lane;
        dmem_wdata = {4{store_data_q[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << {lane[1], 1'b0};
        dmem_wdata = {2{store_data_q[15:0]}};
      end
      default: begin
        dmem_be    = 4'b1111;
        dmem_wdata = store_data_q;
      end
    endcase
  end

  // Load extraction from the returned word, then sign or zero extension.
  always_comb begin
    case (lane)
      2'd0:    load_byte = dmem_rdata[7:0];
      2'd1:    load_byte = dmem_rdata[15:8];
      2'd2:    load_byte = dmem_rdata[23:16];
      default: load_byte = dmem_rdata[31:24];
    endcase
    load_half = lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (size_q)
      2'b00:   load_value = {{24{~unsigned_q & load_byte[7]}}, load_byte};
      2'b01:   load_value = {{16{~unsigned_q & load_half[15]}}, load_half};
      default: load_value = dmem_rdata;
    endcase
  end

  // MEM/WB registers. Completion comes either straight from an accept
  // (non-memory op or trapped access) or from the bus ack in BUSY; the two
  // are exclusive because accept needs IDLE. write_back_ctrl falls back to
  // NO_WRITE_BACK on every cycle without a completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid       <= 1'b0;
      pc_4            <= '0;
      memory_out      <= '0;
      write_back_ctrl <= NO_WRITE_BACK;
      misalign_err    <= 1'b0;
    end else begin
      out_valid       <= 1'b0;
      write_back_ctrl <= NO_WRITE_BACK;
      misalign_err    <= 1'b0;
      if (accept && (!is_mem || trap)) begin
        out_valid       <= 1'b1;
        pc_4            <= pc_4_in;
        memory_out      <= alu_result;
        write_back_ctrl <= trap ? NO_WRITE_BACK : write_back_ctrl_in;
        misalign_err    <= trap;
      end else if ((state == BUSY) && dmem_ack) begin
        out_valid       <= 1'b1;
        pc_4            <= pc_4_q;
        memory_out      <= we_q ? addr_q : load_value;
        write_back_ctrl <= write_back_ctrl_q;
      end
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage
// Scoreboard bench for memory_access_stage. Stimulus pushes the expected bus
// transaction and the expected MEM/WB result; a bus responder and an output
// monitor pop and compare independently. Honours MEM_MISALIGN_TRAP_EN.
module tb_memory_access_stage;
  import params::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  word            alu_result;
  word            store_data;
  word            pc_4_in;
  logic           mem_read;
  logic           mem_write;
  logic [1:0]     mem_size;
  logic           mem_unsigned;
  write_back_op_t write_back_ctrl_in;
  logic           dmem_req;
  logic           dmem_we;
  word            dmem_addr;
  word            dmem_wdata;
  logic [3:0]     dmem_be;
  logic           dmem_ack;
  word            dmem_rdata;
  logic           out_valid;
  word            pc_4;
  word            memory_out;
  write_back_op_t write_back_ctrl;
  logic           misalign_err;

  memory_access_stage dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .alu_result         (alu_result),
    .store_data         (store_data),
    .pc_4_in            (pc_4_in),
    .mem_read           (mem_read),
    .mem_write          (mem_write),
    .mem_size           (mem_size),
    .mem_unsigned       (mem_unsigned),
    .write_back_ctrl_in (write_back_ctrl_in),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_be            (dmem_be),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .out_valid          (out_valid),
    .pc_4               (pc_4),
    .memory_out         (memory_out),
    .write_back_ctrl    (write_back_ctrl),
    .misalign_err       (misalign_err)
  );

  always #5 clk = ~clk;

  // Edge counter: after the edge that samples an event it holds that edge's
  // number, so a registered result appears while cyc equals the edge number.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       we;
    word        addr;
    logic [3:0] be;
    word        wdata;
    word        rdata;
    int         waits;
  } bus_exp_t;

  typedef struct {
    word            pc4;
    word            mout;
    write_back_op_t wb;
    logic           err;
    logic           via_bus;
    int             due;
  } out_exp_t;

  bus_exp_t bus_q[$];
  out_exp_t out_q[$];
  int       ack_q[$];
  bit       auto_resp = 1'b1;

  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model: access width in bytes, natural alignment by modulo,
  // lanes by byte-range membership, load value by shifting and masking.
  task automatic pushExpected(input logic rd, input logic wr, input logic [1:0] size,
                              input logic uns, input word addr, input word sd,
                              input word pc4, input write_back_op_t wb,
                              input word rdata, input int waits);
    int       nbytes;
    int       raw;
    int       off;
    word      v;
    bus_exp_t b;
    out_exp_t o;
    nbytes    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    raw       = int'(addr[1:0]);
    o.pc4     = pc4;
    o.mout    = addr;
    o.wb      = wb;
    o.err     = 1'b0;
    o.via_bus = 1'b0;
    o.due     = cyc;
    if (!(rd || wr)) begin
      out_q.push_back(o);
      return;
    end
`ifdef MEM_MISALIGN_TRAP_EN
    if ((raw % nbytes) != 0) begin
      o.wb  = NO_WRITE_BACK;
      o.err = 1'b1;
      out_q.push_back(o);
      return;
    end
`endif
    off     = raw - (raw % nbytes);
    b.addr  = addr & 32'hFFFF_FFFC;
    b.we    = wr;
    b.rdata = rdata;
    b.waits = waits;
    b.be    = 4'b0000;
    b.wdata = '0;
    for (int i = 0; i < 4; i++) begin
      b.be[i]          = (i >= off) && (i < off + nbytes);
      b.wdata[8*i +: 8] = sd[8*(i % nbytes) +: 8];
    end
    if (rd) begin
      v = rdata >> (8 * off);
      if (nbytes == 1) begin
        v = uns ? (v & 32'h0000_00FF) : {{24{v[7]}}, v[7:0]};
      end else if (nbytes == 2) begin
        v = uns ? (v & 32'h0000_FFFF) : {{16{v[15]}}, v[15:0]};
      end
      o.mout = v;
    end
    o.via_bus = 1'b1;
    bus_q.push_back(b);
    out_q.push_back(o);
  endtask

  // Offer one instruction, wait (bounded) for the accepting edge, then
  // record what the stage must do with it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] size,
                               input logic uns, input word addr, input word sd,
                               input word pc4, input write_back_op_t wb,
                               input word rdata, input int waits);
    logic sampled;
    int   n;
    mem_read           = rd;
    mem_write          = wr;
    mem_size           = size;
    mem_unsigned       = uns;
    alu_result         = addr;
    store_data         = sd;
    pc_4_in            = pc4;
    write_back_ctrl_in = wb;
    in_valid           = 1'b1;
    n                  = 0;
    forever begin
      sampled = in_ready;
      @(posedge clk);
      #1;
      if (sampled) break;
      n++;
      if (n > 50) begin
        checkOutput("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    pushExpected(rd, wr, size, uns, addr, sd, pc4, wb, rdata, waits);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (out_q.size() != 0 || bus_q.size() != 0); k++) begin
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  // Bus responder: checks each request against the expected transaction,
  // holds it for the chosen wait count, then acks with the chosen data.
  initial begin
    bus_exp_t e;
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_resp && !rst && dmem_req) begin
        if (bus_q.size() == 0) begin
          checkOutput("unexpected_req", 32'(dmem_req), 32'd0);
          dmem_ack = 1'b1;
          @(posedge clk);
          #1;
          dmem_ack = 1'b0;
        end else begin
          e = bus_q.pop_front();
          checkOutput("dmem_addr", dmem_addr, e.addr);
          checkOutput("dmem_we", 32'(dmem_we), 32'(e.we));
          if (e.we) begin
            checkOutput("dmem_be", 32'(dmem_be), 32'(e.be));
            checkOutput("dmem_wdata", dmem_wdata, e.wdata);
          end
          for (int k = 0; k < e.waits; k++) begin
            @(negedge clk);
            checkOutput("req_held", 32'(dmem_req), 32'd1);
            checkOutput("busy_in_ready", 32'(in_ready), 32'd0);
            checkOutput("addr_stable", dmem_addr, e.addr);
          end
          dmem_ack   = 1'b1;
          dmem_rdata = e.rdata;
          @(posedge clk);
          #1;
          dmem_ack   = 1'b0;
          dmem_rdata = $urandom;
          ack_q.push_back(cyc);
        end
      end
    end
  end

  // Output monitor: every out_valid pulse must match the oldest expected
  // result, both in value and in the cycle it appears.
  initial begin
    out_exp_t o;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          if (out_q.size() == 0) begin
            checkOutput("unexpected_out_valid", 32'(out_valid), 32'd0);
          end else begin
            o = out_q.pop_front();
            checkOutput("pc_4", pc_4, o.pc4);
            checkOutput("memory_out", memory_out, o.mout);
            checkOutput("write_back_ctrl", 32'(write_back_ctrl), 32'(o.wb));
            checkOutput("misalign_err", 32'(misalign_err), 32'(o.err));
            if (o.via_bus) begin
              if (ack_q.size() == 0) begin
                checkOutput("ack_before_out", 32'd0, 32'd1);
              end else begin
                checkOutput("mem_latency", 32'(cyc), 32'(ack_q.pop_front()));
              end
            end else begin
              checkOutput("op_latency", 32'(cyc), 32'(o.due));
            end
          end
        end else begin
          checkOutput("idle_wb_ctrl", 32'(write_back_ctrl), 32'(NO_WRITE_BACK));
          checkOutput("idle_err", 32'(misalign_err), 32'd0);
        end
      end
    end
  end

  initial begin
    int             kind;
    logic [1:0]     sz;
    write_back_op_t wb;
    rst                = 1'b1;
    in_valid           = 1'b0;
    alu_result         = '0;
    store_data         = '0;
    pc_4_in            = '0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    mem_size           = 2'b00;
    mem_unsigned       = 1'b0;
    write_back_ctrl_in = NO_WRITE_BACK;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pc_4", pc_4, 32'd0);
    checkOutput("rst_memory_out", memory_out, 32'd0);
    checkOutput("rst_wb_ctrl", 32'(write_back_ctrl), 32'(NO_WRITE_BACK));
    checkOutput("rst_misalign_err", 32'(misalign_err), 32'd0);
    checkOutput("rst_dmem_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] directed cases");
    applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 32'h0000_0004,
                  WRITE_BACK_OUT, 32'h0, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h0000_0008,
                  WRITE_BACK_MEM, 32'h80AA_BBCC, 0);
    applyStimulus(1'b1, 1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_000C,
                  WRITE_BACK_MEM, 32'h80AA_BBCC, 0);
    applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_BEEF, 32'h0000_0010,
                  NO_WRITE_BACK, 32'h0, 3);
    applyStimulus(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'h0000_0014,
                  WRITE_BACK_MEM, 32'hDEAD_BEEF, 1);
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'h0, 32'h0000_0018,
                  WRITE_BACK_MEM, 32'h9876_1234, 0);
    drain();

    $display("[TB] randomized cases");
    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      wb   = write_back_op_t'($urandom_range(1, 3));
      if (kind == 0) begin
        applyStimulus(1'b0, 1'b0, sz, 1'($urandom), $urandom, $urandom, $urandom,
                      wb, 32'h0, 0);
      end else if (kind == 1) begin
        applyStimulus(1'b1, 1'b0, sz, 1'($urandom), $urandom, $urandom, $urandom,
                      wb, $urandom, $urandom_range(0, 3));
      end else begin
        applyStimulus(1'b0, 1'b1, sz, 1'b0, $urandom, $urandom, $urandom,
                      NO_WRITE_BACK, 32'h0, $urandom_range(0, 3));
      end
    end
    drain();

    $display("[TB] reset during access");
    auto_resp          = 1'b0;
    @(posedge clk);
    #1;
    mem_read           = 1'b1;
    mem_write          = 1'b0;
    mem_size           = 2'd2;
    mem_unsigned       = 1'b0;
    alu_result         = 32'h0000_0400;
    pc_4_in            = 32'h0000_0040;
    write_back_ctrl_in = WRITE_BACK_MEM;
    in_valid           = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_pre_req", 32'(dmem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_drops_req", 32'(dmem_req), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst        = 1'b0;
    dmem_ack   = 1'b1;
    dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    dmem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_no_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_no_req", 32'(dmem_req), 32'd0);
    end
    checkOutput("rst_pc_4_cleared", pc_4, 32'd0);
    auto_resp = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_0502, 32'h0, 32'h0000_0044,
                  WRITE_BACK_MEM, 32'hF00D_1234, 1);
    applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 32'h0BAD_CAFE, 32'h0, 32'h0000_0048,
                  WRITE_BACK_PC4, 32'h0, 0);
    drain();

    checkOutput("out_q_empty", 32'(out_q.size()), 32'd0);
    checkOutput("bus_q_empty", 32'(bus_q.size()), 32'd0);
    checkOutput("ack_q_empty", 32'(ack_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
